lr_shift_cmd_queue: RTL and testbench
=====================================

// Module: lr_shift_cmd_queue
// PURPOSE
//   Command queue and result register that feeds the left-right shifter stage.
//   Buffers shift commands (bits, amount, dir) from a valid/ready producer, presents the
//   head command to the shifter's iBits/shift/dir inputs, captures the returned oBits,
//   and offers it downstream with a valid/ready handshake and a sequence tag.
// PARAMETERS
//   width  8  data width; matches the shifter's width
//   DEPTH  4  command FIFO entries; power of 2, >=2
//   SEQ_W  8  width of the sequence tag counter
// PORTS
//   clk       in   1               clock; all state updates on rising edge
//   rst       in   1               synchronous reset, active-high
//   inValid   in   1               command valid
//   inReady   out  1               command accepted when inValid&&inReady
//   inBits    in   width           bits to shift
//   inShift   in   $clog2(width)   shift amount
//   inDir     in   1               0=Left, 1=Right (ShiftDir encoding)
//   shIBits   out  width           to shifter iBits (head entry)
//   shShift   out  $clog2(width)   to shifter shift
//   shDir     out  1               to shifter dir
//   shOBits   in   width           combinational result returned by shifter
//   outValid  out  1               result valid
//   outReady  in   1               result consumed when outValid&&outReady
//   oBits     out  width           registered shift result
//   oSeq      out  SEQ_W           tag of the command that produced oBits
//   level     out  $clog2(DEPTH+1) FIFO occupancy (excludes output register)
// BEHAVIOUR
//   Reset: wrPtr=rdPtr=0, level=0, outValid=0, oBits=0, oSeq=0, seq counter=0;
//     all queued commands and held result discarded, also mid-operation.
//   inReady = (level != DEPTH); combinational from level only, never from pop.
//     No push when full, even on a simultaneous pop.
//   push = inValid && inReady: write {inBits,inShift,inDir,seq} at wrPtr; wrPtr++; seq++.
//   Head drive: level!=0 -> sh* = entry[rdPtr]; level==0 -> sh* = 0.
//   pop = (level!=0) && (!outValid || outReady). On pop: oBits<=shOBits,
//     oSeq<=entry[rdPtr].seq, outValid<=1, rdPtr++.
//   outValid cleared when outValid&&outReady&&!pop; held data stable while !outReady.
//   level update: +1 on push only, -1 on pop only, unchanged when both or neither.
//   Latency: command accepted in cycle N is at head in N+1; result valid in N+2 if
//     the output register is free. Full-rate throughput with outReady held high: 1 result/cycle.
//   Capacity: DEPTH commands in FIFO + 1 in output register.
//   Pointers are $clog2(DEPTH) bits and wrap naturally; seq wraps 2^SEQ_W-1 -> 0.
//   Ordering: strict FIFO; oSeq increments by 1 per result, mod 2^SEQ_W.
//   Empty-to-push bypass not allowed: a push in cycle N is never popped in cycle N.
// TESTING  (width=8, DEPTH=4, SEQ_W=8)
//   Reset: rst high 2 cycles -> inReady=1, outValid=0, level=0, oBits=0x00, oSeq=0x00.
//   Single: push 0x81/shift 1/Left at cycle 0, outReady=1 -> cycle 2 outValid=1,
//     oBits=0x02, oSeq=0; next push 0x81/1/Right -> oBits=0x40, oSeq=1.
//   Fill: outReady=0, push continuously from cycle 0 -> 5 commands accepted,
//     inReady=0 with level=4; oBits holds the first result unchanged.
//   Drain/order: from Fill, set outReady=1 -> 5 results on consecutive cycles,
//     oSeq 0..4, each oBits matches a golden shift; level ends at 0.
//   Wrap: 260 pushes, outReady=1 -> oSeq goes 0xFF -> 0x00; no drop or duplicate.
//   Reset mid-op: from Fill, pulse rst 1 cycle -> next cycle outValid=0, level=0,
//     inReady=1; the next push gets oSeq=0.

Source files
------------

// File: rtl/lr_shift_cmd_queue.sv
// Command FIFO plus result register wrapped around an external left/right shifter.
// The head command drives the shifter; its result is captured with a sequence tag.
module lr_shift_cmd_queue #(
  parameter int width = 8,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [width-1:0]           inBits,
  input  logic [$clog2(width)-1:0]   inShift,
  input  logic                       inDir,
  output logic [width-1:0]           shIBits,
  output logic [$clog2(width)-1:0]   shShift,
  output logic                       shDir,
  input  logic [width-1:0]           shOBits,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [width-1:0]           oBits,
  output logic [SEQ_W-1:0]           oSeq,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int SH_W  = $clog2(width);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [width-1:0] bits_mem_r  [DEPTH];
  logic [SH_W-1:0]  shift_mem_r [DEPTH];
  logic             dir_mem_r   [DEPTH];
  logic [SEQ_W-1:0] seq_mem_r   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [SEQ_W-1:0] seq_r;
  logic             out_valid_r;
  logic [width-1:0] o_bits_r;
  logic [SEQ_W-1:0] o_seq_r;

  logic             push_s;
  logic             pop_s;
  logic             not_empty_s;
  logic [width-1:0] sh_bits_s;
  logic [SH_W-1:0]  sh_shift_s;
  logic             sh_dir_s;

  // inReady depends on occupancy alone, so a full queue refuses even while popping
  assign not_empty_s = (level_r != {LVL_W{1'b0}});
  assign inReady     = (level_r != FULL_LVL);
  assign push_s      = inValid && inReady;
  assign pop_s       = not_empty_s && (!out_valid_r || outReady);

  // Head entry drives the shifter; an empty queue presents zeros
  always_comb begin
    sh_bits_s  = {width{1'b0}};
    sh_shift_s = {SH_W{1'b0}};
    sh_dir_s   = 1'b0;
    if (not_empty_s) begin
      sh_bits_s  = bits_mem_r[rd_ptr_r];
      sh_shift_s = shift_mem_r[rd_ptr_r];
      sh_dir_s   = dir_mem_r[rd_ptr_r];
    end else begin
      sh_bits_s  = {width{1'b0}};
      sh_shift_s = {SH_W{1'b0}};
      sh_dir_s   = 1'b0;
    end
  end

  assign shIBits = sh_bits_s;
  assign shShift = sh_shift_s;
  assign shDir   = sh_dir_s;

  // Command storage, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bits_mem_r[i]  <= {width{1'b0}};
        shift_mem_r[i] <= {SH_W{1'b0}};
        dir_mem_r[i]   <= 1'b0;
        seq_mem_r[i]   <= {SEQ_W{1'b0}};
      end
    end else if (push_s) begin
      bits_mem_r[wr_ptr_r]  <= inBits;
      shift_mem_r[wr_ptr_r] <= inShift;
      dir_mem_r[wr_ptr_r]   <= inDir;
      seq_mem_r[wr_ptr_r]   <= seq_r;
    end
  end

  // Pointers, occupancy and tag counter; pointers and tag wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      seq_r    <= {SEQ_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        seq_r    <= seq_r + SEQ_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Output register: loads on pop, otherwise holds until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      o_bits_r    <= {width{1'b0}};
      o_seq_r     <= {SEQ_W{1'b0}};
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      o_bits_r    <= shOBits;
      o_seq_r     <= seq_mem_r[rd_ptr_r];
    end else if (out_valid_r && outReady) begin
      out_valid_r <= 1'b0;
    end
  end

  assign outValid = out_valid_r;
  assign oBits    = o_bits_r;
  assign oSeq     = o_seq_r;
  assign level    = level_r;

endmodule

// File: tb/tb_lr_shift_cmd_queue.sv
// Self-checking bench for lr_shift_cmd_queue: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_lr_shift_cmd_queue;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] inBits;
  logic [2:0] inShift;
  logic       inDir;
  logic [7:0] shIBits;
  logic [2:0] shShift;
  logic       shDir;
  logic [7:0] shOBits;
  logic       outValid;
  logic       outReady;
  logic [7:0] oBits;
  logic [7:0] oSeq;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  lr_shift_cmd_queue #(.width(8), .DEPTH(4), .SEQ_W(8)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady),
    .inBits(inBits), .inShift(inShift), .inDir(inDir),
    .shIBits(shIBits), .shShift(shShift), .shDir(shDir),
    .shOBits(shOBits),
    .outValid(outValid), .outReady(outReady),
    .oBits(oBits), .oSeq(oSeq), .level(level)
  );

  function automatic logic [7:0] gold(input logic [7:0] b, input logic [2:0] s, input logic d);
    return d ? (b >> s) : (b << s);
  endfunction

  // Stand-in for the shifter stage
  assign shOBits = gold(shIBits, shShift, shDir);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;
    logic [2:0] sh;
    logic       dir;
    logic [7:0] seq;
  } cmd_t;

  cmd_t       mq[$];
  logic       m_valid;
  logic [7:0] m_obits;
  logic [7:0] m_oseq;
  logic [7:0] m_seq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: predict handshakes from the model, advance both, compare
  task automatic tick();
    logic m_push;
    logic m_pop;
    cmd_t c;
    m_push = inValid && (mq.size() < 4);
    m_pop  = (mq.size() != 0) && (!m_valid || outReady);
    if (!rst) begin
      if (mq.size() != 0) begin
        chk("head_bits", 32'(shIBits), 32'(mq[0].bits));
        chk("head_shift", 32'(shShift), 32'(mq[0].sh));
        chk("head_dir", 32'(shDir), 32'(mq[0].dir));
      end else begin
        chk("head_idle", 32'({shIBits, shShift, shDir}), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_obits = 8'h00;
      m_oseq  = 8'h00;
      m_seq   = 8'h00;
    end else begin
      if (m_pop) begin
        c = mq.pop_front();
        m_obits = gold(c.bits, c.sh, c.dir);
        m_oseq  = c.seq;
        m_valid = 1'b1;
      end else if (m_valid && outReady) begin
        m_valid = 1'b0;
      end
      if (m_push) begin
        c.bits = inBits; c.sh = inShift; c.dir = inDir; c.seq = m_seq;
        mq.push_back(c);
        m_seq = m_seq + 8'd1;
      end
    end
    chk("m_outValid", 32'(outValid), 32'(m_valid));
    chk("m_oBits", 32'(oBits), 32'(m_obits));
    chk("m_oSeq", 32'(oSeq), 32'(m_oseq));
    chk("m_level", 32'(level), 32'(mq.size()));
    chk("m_inReady", 32'(inReady), 32'(mq.size() != 4));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    inValid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  logic [7:0] fill_bits [8];

  // Push continuously with the consumer stalled; returns number accepted
  task automatic fill_up(output int accepted);
    accepted = 0;
    outReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      inValid = 1'b1;
      inBits  = fill_bits[c];
      inShift = 3'(c);
      inDir   = c[0];
      if (inReady) accepted++;
      tick();
    end
    inValid = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] b;
    logic [2:0] s;
    logic       d;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_ob;
    logic [7:0] e_os;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int accepted;
    int pushed;
    int results;
    int cyc;
    logic [7:0] exp_seq;
    logic [7:0] prev_seq;
    logic saw_wrap;

    vecs[0] = '{1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd1};
    vecs[1] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 3'd0};
    vecs[2] = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 3'd1};
    vecs[3] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h01, 3'd0};
    vecs[4] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h01, 3'd0};
    for (int i = 0; i < 8; i++) fill_bits[i] = 8'(8'h5B + i * 8'h2F);

    rst = 1'b1; inValid = 1'b0; inBits = 8'h00; inShift = 3'd0; inDir = 1'b0;
    outReady = 1'b1;
    m_valid = 1'b0; m_obits = 8'h00; m_oseq = 8'h00; m_seq = 8'h00;

    // Reset state
    do_reset(2);
    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_oBits", 32'(oBits), 32'h00);
    chk("rst_oSeq", 32'(oSeq), 32'h00);

    // Single-command vectors
    for (int i = 0; i < 5; i++) begin
      inValid = vecs[i].iv; inBits = vecs[i].b; inShift = vecs[i].s;
      inDir = vecs[i].d; outReady = vecs[i].ordy;
      tick();
      chk("tbl_outValid", 32'(outValid), 32'(vecs[i].e_ov));
      chk("tbl_oBits", 32'(oBits), 32'(vecs[i].e_ob));
      chk("tbl_oSeq", 32'(oSeq), 32'(vecs[i].e_os));
      chk("tbl_level", 32'(level), 32'(vecs[i].e_lvl));
    end

    // Fill then drain in order
    do_reset(1);
    fill_up(accepted);
    chk("fill_accepted", 32'(accepted), 32'd5);
    chk("fill_inReady", 32'(inReady), 32'd0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_oBits", 32'(oBits), 32'(gold(fill_bits[0], 3'd0, 1'b0)));
    outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_outValid", 32'(outValid), 32'd1);
      chk("drain_oSeq", 32'(oSeq), 32'(k));
      chk("drain_oBits", 32'(oBits), 32'(gold(fill_bits[k], 3'(k), k[0])));
      tick();
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_outValid_end", 32'(outValid), 32'd0);

    // Reset in the middle of a full queue
    fill_up(accepted);
    do_reset(1);
    chk("mid_outValid", 32'(outValid), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_inReady", 32'(inReady), 32'd1);
    outReady = 1'b1;
    inValid = 1'b1; inBits = 8'hC3; inShift = 3'd2; inDir = 1'b1;
    tick();
    inValid = 1'b0;
    cyc = 0;
    while (!outValid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("mid_timeout", 32'(outValid), 32'd1);
    chk("mid_oSeq", 32'(oSeq), 32'h00);
    chk("mid_oBits", 32'(oBits), 32'h30);

    // Tag wrap over 260 commands at full rate
    do_reset(1);
    outReady = 1'b1;
    pushed = 0; results = 0; cyc = 0;
    exp_seq = 8'h00; prev_seq = 8'h00; saw_wrap = 1'b0;
    while (results < 260 && cyc < 600) begin
      if (outValid && outReady) begin
        chk("wrap_oSeq", 32'(oSeq), 32'(exp_seq));
        if (results > 0 && prev_seq == 8'hFF && oSeq == 8'h00) saw_wrap = 1'b1;
        prev_seq = oSeq;
        exp_seq = exp_seq + 8'd1;
        results++;
      end
      inValid = (pushed < 260);
      inBits = 8'($urandom); inShift = 3'($urandom); inDir = 1'($urandom);
      if (inValid && inReady) pushed++;
      tick();
      cyc++;
    end
    chk("wrap_results", 32'(results), 32'd260);
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_fullrate", 32'(cyc <= 264), 32'd1);

    // Randomized traffic with bursts of backpressure
    inValid = 1'b0;
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      inValid  = ($urandom_range(3) != 0);
      outReady = (i % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(4) != 0);
      inBits   = 8'($urandom);
      inShift  = 3'($urandom);
      inDir    = 1'($urandom);
      if (i == 900) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
